// File: rtl/clint_resp.sv
// Core-local interrupt responder: msip, mtimecmp and free-running mtime behind a single-beat request/response port.
// Optional build macro CLINT_PRESCALER_EN: mtime advances once every TICK_DIV cycles instead of every cycle.
module clint_resp #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] BASE     = 64'h0000_0000_0200_0000,
  parameter int unsigned     TICK_DIV = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wen,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [7:0]      req_wmask,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            msip,
  output logic            mtip
);

  localparam logic [XLEN-1:0] ADDR_MSIP     = BASE;
  localparam logic [XLEN-1:0] ADDR_MTIMECMP = BASE + XLEN'(32'h0000_4000);
  localparam logic [XLEN-1:0] ADDR_MTIME    = BASE + XLEN'(32'h0000_BFF8);

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_RESP = 1'b1;

  if (TICK_DIV < 1) begin : g_tick_div_check
    $error("clint_resp: TICK_DIV must be at least 1");
  end

  function automatic logic [XLEN-1:0] merge_bytes(input logic [XLEN-1:0] old_val,
                                                  input logic [XLEN-1:0] new_val,
                                                  input logic [7:0]      be);
    logic [XLEN-1:0] r;
    r = old_val;
    for (int i = 0; i < 8; i++) begin
      if (be[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

  logic            state_q, state_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            msip_q, msip_d;
  logic [XLEN-1:0] mtimecmp_q, mtimecmp_d;
  logic [XLEN-1:0] mtime_q, mtime_d;
  logic            mtip_q, mtip_d;

  logic accept;
  logic hit_msip, hit_cmp, hit_time;
  logic wr_msip, wr_cmp, wr_time;
  logic tick;

  assign accept   = (state_q == STATE_IDLE) && req_valid;
  assign hit_msip = (req_addr == ADDR_MSIP);
  assign hit_cmp  = (req_addr == ADDR_MTIMECMP);
  assign hit_time = (req_addr == ADDR_MTIME);
  assign wr_msip  = accept && req_wen && hit_msip;
  assign wr_cmp   = accept && req_wen && hit_cmp;
  assign wr_time  = accept && req_wen && hit_time;

`ifdef CLINT_PRESCALER_EN
  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CNT_W'(TICK_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    if (wr_time) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (state_q == STATE_IDLE) begin
      if (req_valid) begin
        state_d = STATE_RESP;
        err_d   = ~(hit_msip | hit_cmp | hit_time);
        rdata_d = '0;
        if (!req_wen) begin
          if (hit_msip)      rdata_d = {{(XLEN-1){1'b0}}, msip_q};
          else if (hit_cmp)  rdata_d = mtimecmp_q;
          else if (hit_time) rdata_d = mtime_q;
        end
      end
    end else if (resp_ready) begin
      state_d = STATE_IDLE;
    end
  end

  // A store to mtime overrides the tick on the same edge; mtip sees post-update values.
  always_comb begin
    msip_d     = (wr_msip && req_wmask[0]) ? req_wdata[0] : msip_q;
    mtimecmp_d = wr_cmp ? merge_bytes(mtimecmp_q, req_wdata, req_wmask) : mtimecmp_q;
    if (wr_time)   mtime_d = merge_bytes(mtime_q, req_wdata, req_wmask);
    else if (tick) mtime_d = mtime_q + XLEN'(1);
    else           mtime_d = mtime_q;
    mtip_d = (mtime_d >= mtimecmp_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= STATE_IDLE;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      msip_q     <= 1'b0;
      mtimecmp_q <= '1;
      mtime_q    <= '0;
      mtip_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      msip_q     <= msip_d;
      mtimecmp_q <= mtimecmp_d;
      mtime_q    <= mtime_d;
      mtip_q     <= mtip_d;
    end
  end

  assign req_ready  = (state_q == STATE_IDLE);
  assign resp_valid = (state_q == STATE_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign msip       = msip_q;
  assign mtip       = mtip_q;

endmodule

// File: tb/tb_clint_resp.sv
// Bench for clint_resp: directed and random requests checked against a timeline model of the timer registers.
module tb_clint_resp;

  localparam logic [63:0] BASE     = 64'h0000_0000_0200_0000;
  localparam int unsigned TICK_DIV = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wmask = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        msip;
  logic        mtip;

  clint_resp #(.XLEN(64), .BASE(BASE), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .msip(msip), .mtip(mtip)
  );

  always #5 clk = ~clk;

  int unsigned edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int passed = 0;
  int total  = 0;

  // Model: mtime is an anchor value plus the ticks elapsed since the anchor edge.
  logic        m_msip;
  logic [63:0] m_cmp;
  logic [63:0] a_val;
  int unsigned a_edge;

  function automatic logic [63:0] mt_at(input int unsigned e);
    int unsigned d;
    d = e - a_edge;
`ifdef CLINT_PRESCALER_EN
    return a_val + 64'(d / TICK_DIV);
`else
    return a_val + 64'(d);
`endif
  endfunction

  function automatic logic [63:0] apply_mask(input logic [63:0] old_v, input logic [63:0] new_v,
                                             input logic [7:0] be);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) m = m | ({64{be[i]}} & (64'hFF << (8 * i)));
    return (old_v & ~m) | (new_v & m);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_irq(input string tag);
    chk({tag, "_msip"}, {63'b0, msip}, {63'b0, m_msip});
    chk({tag, "_mtip"}, {63'b0, mtip}, {63'b0, (mt_at(edge_n) >= m_cmp)});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    a_edge = edge_n;
    a_val  = '0;
    m_cmp  = '1;
    m_msip = 1'b0;
    chk("rst_req_ready", {63'b0, req_ready}, 64'd1);
    chk("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
    chk("rst_rdata", resp_rdata, 64'd0);
    chk("rst_err", {63'b0, resp_err}, 64'd0);
    check_irq("rst");
  endtask

  task automatic do_req(input string tag, input logic wen, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [7:0] wmask, input int hold);
    int unsigned acc;
    logic [63:0] exp_rd, off;
    logic        exp_err;
    @(negedge clk);
    chk({tag, "_ready"}, {63'b0, req_ready}, 64'd1);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = wmask;
    resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    acc = edge_n;
    // Junk request while the response is pending must be ignored.
    req_valid = 1'(($urandom % 2)); req_wen = 1'b1; req_addr = BASE; req_wdata = '1; req_wmask = 8'hFF;
    off = addr - BASE;
    exp_rd = '0;
    exp_err = !(off == 64'h0 || off == 64'h4000 || off == 64'hBFF8);
    if (!wen) begin
      if (off == 64'h0)         exp_rd = {63'b0, m_msip};
      else if (off == 64'h4000) exp_rd = m_cmp;
      else if (off == 64'hBFF8) exp_rd = mt_at(acc - 1);
    end else begin
      if (off == 64'h0 && wmask[0]) m_msip = wdata[0];
      else if (off == 64'h4000)     m_cmp = apply_mask(m_cmp, wdata, wmask);
      else if (off == 64'hBFF8) begin
        a_val  = apply_mask(mt_at(acc - 1), wdata, wmask);
        a_edge = acc;
      end
    end
    chk({tag, "_resp_valid"}, {63'b0, resp_valid}, 64'd1);
    chk({tag, "_busy"}, {63'b0, req_ready}, 64'd0);
    chk({tag, "_rdata"}, resp_rdata, exp_rd);
    chk({tag, "_err"}, {63'b0, resp_err}, {63'b0, exp_err});
    check_irq(tag);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, {63'b0, resp_valid}, 64'd1);
      chk({tag, "_hold_busy"}, {63'b0, req_ready}, 64'd0);
      chk({tag, "_hold_rdata"}, resp_rdata, exp_rd);
      chk({tag, "_hold_err"}, {63'b0, resp_err}, {63'b0, exp_err});
      check_irq(tag);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0; req_valid = 1'b0;
    chk({tag, "_done_valid"}, {63'b0, resp_valid}, 64'd0);
    chk({tag, "_done_ready"}, {63'b0, req_ready}, 64'd1);
    check_irq(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    do_reset();

    do_req("load_cmp", 1'b0, BASE + 64'h4000, '0, 8'h00, 0);

    do_req("st_cmp5", 1'b1, BASE + 64'h4000, 64'd5, 8'hFF, 0);
    do_req("st_time0", 1'b1, BASE + 64'hBFF8, 64'd0, 8'hFF, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_irq("mtip_rise");
    end
    do_req("st_cmp_max", 1'b1, BASE + 64'h4000, '1, 8'hFF, 0);

    do_req("st_msip", 1'b1, BASE, 64'hFF, 8'h01, 0);
    do_req("ld_msip", 1'b0, BASE, '0, 8'h00, 0);
    do_req("st_msip_nomask", 1'b1, BASE, 64'h0, 8'h00, 0);
    do_req("ld_msip2", 1'b0, BASE, '0, 8'h00, 1);

    do_req("st_time_wrap", 1'b1, BASE + 64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0);
    do_req("ld_time_wrap", 1'b0, BASE + 64'hBFF8, '0, 8'h00, 0);
    do_req("st_time_tick", 1'b1, BASE + 64'hBFF8, 64'h1234, 8'hFF, 0);
    do_req("ld_time_tick", 1'b0, BASE + 64'hBFF8, '0, 8'h00, 0);
    do_req("st_time_part", 1'b1, BASE + 64'hBFF8, 64'hAABB_CCDD_0000_0000, 8'hF0, 0);
    do_req("ld_time_part", 1'b0, BASE + 64'hBFF8, '0, 8'h00, 2);

    do_req("ld_bad", 1'b0, BASE + 64'h8, '0, 8'h00, 3);
    do_req("st_bad", 1'b1, BASE + 64'h10, '1, 8'hFF, 1);

    for (int n = 0; n < 40; n++) begin
      logic [63:0] addr, wdata;
      logic [7:0]  be;
      logic        wen;
      int          sel;
      sel = int'($urandom_range(0, 3));
      addr = (sel == 0) ? BASE : (sel == 1) ? BASE + 64'h4000 :
             (sel == 2) ? BASE + 64'hBFF8 : BASE + 64'h100;
      wen   = 1'($urandom % 2);
      wdata = {$urandom, $urandom};
      if (sel == 2 && ($urandom % 2) == 1) wdata = {32'h0, 24'h0, 8'($urandom)};
      if (sel == 1 && ($urandom % 2) == 1) wdata = {48'h0, 16'($urandom)};
      be = 8'($urandom);
      do_req("rand", wen, addr, wdata, be, int'($urandom_range(0, 3)));
    end

    // Reset while a response is pending.
    do_req("pre_rst_cmp", 1'b1, BASE + 64'h4000, 64'd0, 8'hFF, 0);
    do_req("pre_rst_msip", 1'b1, BASE, 64'd1, 8'h01, 0);
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = BASE + 64'hBFF8;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_resp_valid", {63'b0, resp_valid}, 64'd1);
    rst = 1'b1; resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; resp_ready = 1'b0;
    a_edge = edge_n; a_val = '0; m_cmp = '1; m_msip = 1'b0;
    chk("mid_rst_valid", {63'b0, resp_valid}, 64'd0);
    chk("mid_rst_ready", {63'b0, req_ready}, 64'd1);
    chk("mid_rst_rdata", resp_rdata, 64'd0);
    check_irq("mid_rst");
    do_req("post_rst_time", 1'b0, BASE + 64'hBFF8, '0, 8'h00, 0);
    do_req("post_rst_cmp", 1'b0, BASE + 64'h4000, '0, 8'h00, 0);

`ifdef CLINT_PRESCALER_EN
    do_reset();
    repeat (29) @(negedge clk);
    do_req("presc_30", 1'b0, BASE + 64'hBFF8, '0, 8'h00, 0);
    chk("presc_model_3", mt_at(a_edge + 30), 64'd3);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
